// File: rtl/biquad8_coeff_loader.sv
// biquad8_coeff_loader: writer side of the biquad8 incremental-IIR coefficient
// shift interface. The host fills a staging buffer, then a single commit shifts
// the whole set into the B1 cascade chain (highest index first), waits GAP
// idle clocks and pulses coeff_update_o so every B2 register loads at once.
// A commit arriving during a sequence is held in a one-deep pending flag.
// Optional feature macro: BIQUAD8_COEFF_LOADER_READBACK_EN adds rdat_o, a
// registered readback of staging[stg_addr_i].
module biquad8_coeff_loader #(
  parameter int NSAMP    = 8,
  parameter int ADDRBITS = 4,
  parameter int GAP      = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDRBITS-1:0] stg_addr_i,
  input  logic [17:0]         stg_dat_i,
  input  logic                stg_wr_i,
  input  logic                commit_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  output logic [17:0]         coeff_dat_o,
  output logic                coeff_wr_o,
`ifdef BIQUAD8_COEFF_LOADER_READBACK_EN
  output logic                coeff_update_o,
  output logic [17:0]         rdat_o
`else
  output logic                coeff_update_o
`endif
);

  localparam int NCOEFF = 2 * (NSAMP - 2);
  localparam int DEPTH  = 1 << ADDRBITS;
  localparam int GAPW   = (GAP < 2) ? 1 : $clog2(GAP + 1);
  localparam logic [ADDRBITS-1:0] LAST_IDX = ADDRBITS'(NCOEFF - 1);
  localparam logic [ADDRBITS:0]   NCOEFF_W = (ADDRBITS + 1)'(NCOEFF);
  localparam logic [GAPW-1:0]     GAP_LOAD = (GAP > 0) ? GAPW'(GAP - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SHIFT = 3'd1,
    S_GAP   = 3'd2,
    S_UPD   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Staging buffer is sized to the full address space so any readback address
  // is in range; only indices below NCOEFF are ever written.
  logic [17:0] stg_mem [0:DEPTH-1];

  state_t              state_q, state_d;
  logic [ADDRBITS-1:0] cnt_q, cnt_d;
  logic [GAPW-1:0]     gap_q, gap_d;
  logic                pend_q, pend_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                wr_q, wr_d;
  logic                upd_q, upd_d;
  logic [17:0]         dat_q, dat_d;
  logic                addr_ok_s;
  logic                stg_we_s;

  assign addr_ok_s = ({1'b0, stg_addr_i} < NCOEFF_W);
  assign stg_we_s  = stg_wr_i & ~busy_q & addr_ok_s;

  // Staging write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (stg_we_s) begin
      stg_mem[stg_addr_i] <= stg_dat_i;
    end
  end

  // State, counters, sticky flags and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
      pend_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wr_q    <= 1'b0;
      upd_q   <= 1'b0;
      dat_q   <= 18'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      wr_q    <= wr_d;
      upd_q   <= upd_d;
      dat_q   <= dat_d;
    end
  end

  // Next-state logic, word/gap counters and pending-commit tracking.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    pend_d  = pend_q;
    case (state_q)
      S_IDLE: begin
        if (commit_i) begin
          state_d = S_SHIFT;
          cnt_d   = LAST_IDX;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (cnt_q == '0) begin
          if (GAP > 0) begin
            state_d = S_GAP;
            gap_d   = GAP_LOAD;
          end else begin
            state_d = S_UPD;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_GAP: begin
        if (gap_q == '0) begin
          state_d = S_UPD;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      S_UPD: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        // busy_o is low here, so a commit in this cycle starts directly.
        if (pend_q || commit_i) begin
          state_d = S_SHIFT;
          cnt_d   = LAST_IDX;
          pend_d  = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        gap_d   = '0;
        pend_d  = 1'b0;
      end
    endcase
    if (busy_q && commit_i) begin
      pend_d = 1'b1;
    end else begin
      pend_d = pend_d;
    end
  end

  // Output decode from the next state so every strobe is a plain flop; data
  // is taken from the current SHIFT word, giving the one-clock lag behind wr.
  always_comb begin
    busy_d = (state_d == S_SHIFT) || (state_d == S_GAP) || (state_d == S_UPD);
    wr_d   = (state_d == S_SHIFT);
    upd_d  = (state_d == S_UPD);
    done_d = (state_d == S_DONE);
    err_d  = err_q | (stg_wr_i & (busy_q | ~addr_ok_s));
    if (state_q == S_SHIFT) begin
      dat_d = stg_mem[cnt_q];
    end else begin
      dat_d = 18'd0;
    end
  end

  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign err_o          = err_q;
  assign coeff_dat_o    = dat_q;
  assign coeff_wr_o     = wr_q;
  assign coeff_update_o = upd_q;

`ifdef BIQUAD8_COEFF_LOADER_READBACK_EN
  logic [17:0] rdat_q, rdat_d;

  // Readback mux; allowed at any time, including mid-sequence.
  always_comb begin
    rdat_d = stg_mem[stg_addr_i];
  end

  // Registered readback data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdat_q <= 18'd0;
    end else begin
      rdat_q <= rdat_d;
    end
  end

  assign rdat_o = rdat_q;
`endif

endmodule
